// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchronizer, counter debounce and registered
// rise/fall pulse generation for N_BTN independent channels.
module btn_conditioner #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             any_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] rise_q;
  logic [N_BTN-1:0] rise_d;
  logic [N_BTN-1:0] fall_q;
  logic [N_BTN-1:0] fall_d;
  logic             any_rise_q;
  logic             any_rise_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Any return to the accepted level restarts the window, so bounces never accumulate.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d     = level_d & ~level_q;
    fall_d     = ~level_d & level_q;
    any_rise_d = |rise_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      any_rise_q <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_rise_q <= any_rise_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign any_rise  = any_rise_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios then random bouncing inputs, checked
// each cycle against a window-based reference model of the debounce rules.
module tb_btn_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int HMAX = 4096;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic         any_rise;

  btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .any_rise  (any_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: history of what was applied at each edge.
  logic [N-1:0] raw_h [HMAX];
  logic         rst_h [HMAX];
  int           t = 0;
  int           last_evt [N];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_fall  = '0;

  // Value the debouncer sees at edge k: the raw sample from two edges earlier,
  // or 0 if a reset landed inside that synchronizer delay.
  function automatic logic seen(input int k, input int ch);
    if (k < 2) return 1'b0;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
    return raw_h[k-2][ch];
  endfunction

  task automatic step(input logic [N-1:0] raw, input logic r);
    logic ok;
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    #1;
    raw_h[t] = raw;
    rst_h[t] = r;
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      m_level = '0;
      for (int i = 0; i < N; i++) last_evt[i] = t;
    end else begin
      // A level flips when the last DB seen values, all after the previous
      // flip or reset, disagree with the current level.
      for (int ch = 0; ch < N; ch++) begin
        ok = (t - DB + 1 > last_evt[ch]);
        for (int k = t - DB + 1; k <= t; k++) begin
          if (ok && seen(k, ch) == m_level[ch]) ok = 1'b0;
        end
        if (ok) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) m_rise[ch] = 1'b1;
          else             m_fall[ch] = 1'b1;
          last_evt[ch] = t;
        end
      end
    end
    t++;
    n_cmp++;
    assert (btn_level === m_level) else begin
      n_fail++;
      $error("FAIL level t=%0d observed=%b expected=%b", t, btn_level, m_level);
    end
    n_cmp++;
    assert ({btn_rise, btn_fall, any_rise} === {m_rise, m_fall, |m_rise}) else begin
      n_fail++;
      $error("FAIL pulses t=%0d observed rise/fall/any=%b/%b/%b expected=%b/%b/%b",
             t, btn_rise, btn_fall, any_rise, m_rise, m_fall, |m_rise);
    end
    $display("t=%0d rst=%b raw=%b level=%b rise=%b fall=%b any=%b",
             t, r, raw, btn_level, btn_rise, btn_fall, any_rise);
  endtask

  task automatic hand_check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [N-1:0] cur;
  int           hold [N];

  initial begin
    btn_raw = '0;
    rst     = 1'b1;
    for (int i = 0; i < N; i++) last_evt[i] = -100;

    // Reset with all buttons held: outputs stay low, then a press 6 edges after release.
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1);
      hand_check("reset_level", btn_level, 4'b0000);
      hand_check("reset_rise", btn_rise, 4'b0000);
    end
    for (int i = 1; i <= 5; i++) begin
      step(4'b1111, 1'b0);
      hand_check("post_reset_wait", btn_level, 4'b0000);
    end
    step(4'b1111, 1'b0);
    hand_check("post_reset_level", btn_level, 4'b1111);
    hand_check("post_reset_rise", btn_rise, 4'b1111);
    hand_check("post_reset_any", {3'b000, any_rise}, 4'b0001);
    step(4'b1111, 1'b0);
    hand_check("post_reset_rise_once", btn_rise, 4'b0000);
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

    // Clean press on channel 2.
    for (int i = 1; i <= 20; i++) begin
      step(4'b0100, 1'b0);
      if (i == 5) hand_check("press_wait", btn_level, 4'b0000);
      if (i == 6) hand_check("press_rise", btn_rise, 4'b0100);
      if (i == 7) hand_check("press_rise_once", btn_rise, 4'b0000);
    end

    // Bounce on channel 0, then steady high.
    step(4'b0101, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0100, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(4'b0101, 1'b0);
      if (i == 5) hand_check("bounce_wait", btn_level, 4'b0100);
      if (i == 6) hand_check("bounce_rise", btn_rise, 4'b0001);
    end

    // Short glitch on channel 1 is ignored.
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(4'b0101, 1'b0);
      hand_check("glitch_level", btn_level, 4'b0101);
    end

    // Press and release on channel 3.
    for (int i = 0; i < 12; i++) step(4'b1101, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(4'b0101, 1'b0);
      if (i == 6) hand_check("release_fall", btn_fall, 4'b1000);
      if (i == 7) hand_check("release_level", btn_level, 4'b0101);
    end

    // Reset in the middle of a debounce window on channel 0.
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b1);
    hand_check("midreset_level", btn_level, 4'b0000);
    for (int i = 1; i <= 12; i++) begin
      step(4'b0101, 1'b0);
      if (i == 5) hand_check("midreset_wait", btn_rise, 4'b0000);
      if (i == 6) hand_check("midreset_rise", btn_rise, 4'b0101);
    end

    // Random bouncing inputs with occasional resets.
    cur = '0;
    for (int i = 0; i < N; i++) hold[i] = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          cur[i]  = ~cur[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 12));
        end
      end
      step(cur, ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side front end for the reaction-timer board design: converts raw, asynchronous, bouncing push-button inputs into clean, clock-synchronous level and single-cycle edge signals.
- Per button: 2-flop synchronizer, counter-based debounce, then rise/fall pulse generation.
- Sits between board buttons (rst, clear, start, stop) and the timer core, so the core sees exactly one start/stop/clear pulse per physical press.

Parameters:
- N_BTN, 4, number of independent button channels.
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); must be >= 1.
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES-1.

Ports:
- clk  input  1  system clock (100 MHz on board).
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  raw button pins, asynchronous to clk, active-high.
- btn_level  output  N_BTN  debounced button state, registered.
- btn_rise  output  N_BTN  one-cycle pulse on debounced press (0->1).
- btn_fall  output  N_BTN  one-cycle pulse on debounced release (1->0).
- any_rise  output  1  OR of btn_rise, registered identically (same cycle as btn_rise).

Behaviour:
- One clock, clk. rst is sampled only on the rising edge of clk, is active-high, and has priority over all other logic.
- On reset, all of the following clear to 0: synchronizer flops, per-channel counters, btn_level, btn_rise, btn_fall, any_rise.
- Synchronizer: sync1[i] <= btn_raw[i]; sync2[i] <= sync1[i]. A raw change becomes visible on sync2 two edges later.
- Per-channel debounce counter cnt[i]:
  - If sync2[i] == btn_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: btn_level[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
- Latency: raw input stable from edge E -> btn_level updates at edge E + 2 + DB_CYCLES - 1, i.e. visible in the cycle after that edge. Fixed, with no early acceptance.
- A mismatch lasting fewer than DB_CYCLES consecutive cycles is ignored. The counter restarts from 0 on any return to the current level, so bounces restart the window.
- Edges:
  - btn_rise[i] is registered and asserts for exactly one cycle, in the same cycle btn_level[i] first reads 1.
  - btn_fall[i] behaves the same way for a transition to 0.
  - rise and fall are never asserted together on one channel.
  - any_rise is high in exactly the cycles in which some btn_rise bit is high.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses with no arbitration.
- Counter never wraps: the terminal compare at DB_CYCLES-1 always fires first.
- Reset mid-count discards progress. A button held through reset release is treated as a new press: btn_rise fires 2 + DB_CYCLES cycles after rst deasserts.
- DB_CYCLES = 1: level follows sync2 one cycle later, and edge pulses still apply.

Test Plan:
All scenarios use N_BTN=4, DB_CYCLES=4, CNT_W=3.
- Reset: hold rst 3 cycles with btn_raw=4'b1111 -> all outputs 0 during reset. After release, btn_level=4'b1111 after 6 cycles, with btn_rise=4'b1111 and any_rise=1 for exactly 1 cycle.
- Clean press: btn_raw[2] 0->1 held 20 cycles -> btn_level[2] rises 6 cycles after the raw edge, btn_rise[2] high 1 cycle, other channels unchanged.
- Bounce: btn_raw[0] toggles 1,0,1,1,0,1 on consecutive cycles, then holds 1 -> exactly one btn_rise[0], 6 cycles after the final 0->1; no btn_fall[0].
- Glitch: btn_raw[1] high for 3 cycles only (less than DB_CYCLES) -> btn_level[1] stays 0, no pulses.
- Release: after a debounced press, drop btn_raw[3] and hold 0 -> btn_fall[3] for 1 cycle, 6 cycles after the drop, and btn_level[3]=0.
- Mid-count reset: raise btn_raw[0], assert rst 3 cycles later for 1 cycle, keep raw high -> no rise before reset. btn_rise[0] occurs 6 cycles after rst deasserts.
